// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the two-requester UART transmit scheduler.
package uart_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_SEND  = 2'd2,
      ST_WAIT  = 2'd3
   } sched_state_e;

   typedef logic req_id_t;

   localparam logic [7:0] HEADER_BASE = 8'hA0;

   function automatic logic [7:0] header_byte(input req_id_t id);
      return HEADER_BASE | {7'b000_0000, id};
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; the last-grant register moves only when update_i is set.
module rr_arbiter2
   import uart_sched_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req_i,
   input  logic       update_i,
   output logic [1:0] grant_o
);

   req_id_t last_q;
   req_id_t last_d;

   // Winner selection: on a tie, favour the requester not served last.
   always_comb begin
      grant_o = 2'b00;
      case (req_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = (last_q == 1'b1) ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
   end

   // Pointer next-state: only a real grant moves it.
   always_comb begin
      last_d = last_q;
      if (update_i && (grant_o != 2'b00)) begin
         last_d = grant_o[1];
      end else begin
         last_d = last_q;
      end
   end

   // Pointer register; reset value makes requester 0 win the first tie.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one 8N1 byte transmitter between two word producers, sending each
// granted word as an optional header byte followed by its payload LSB-first.
module uart_tx_scheduler
   import uart_sched_pkg::*;
#(
   parameter int unsigned WORD_BYTES  = 4,
   parameter int unsigned SEND_HEADER = 1
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [1:0]              i_req,
   input  logic [8*WORD_BYTES-1:0] i_word0,
   input  logic [8*WORD_BYTES-1:0] i_word1,
   output logic [1:0]              o_grant,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_done_id,
   output logic                    o_data_avail,
   output logic [7:0]              o_data_byte,
   input  logic                    i_tx_active,
   input  logic                    i_tx_done
);

   localparam int unsigned   W       = 8 * WORD_BYTES;
   localparam int unsigned   CW      = $clog2(WORD_BYTES + 2);
   localparam logic [CW-1:0] N_BYTES = CW'(WORD_BYTES + SEND_HEADER);
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam bit            HDR_EN  = (SEND_HEADER != 0);

   sched_state_e  state_q, state_d;
   logic [W-1:0]  shift_q, shift_d;
   req_id_t       id_q, id_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          hdr_q, hdr_d;
   logic [1:0]    grant_q, grant_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   req_id_t       done_id_q, done_id_d;
   logic          avail_q, avail_d;
   logic [7:0]    byte_q, byte_d;

   logic          arb_update_s;
   logic [1:0]    arb_grant_s;

   // Arbitrate only when idle and the transmitter has finished any byte left over from a reset.
   assign arb_update_s = (state_q == ST_IDLE) && (i_req != 2'b00) && !i_tx_active;

   rr_arbiter2 u_arb (
      .clk_i    (clock),
      .rst_ni   (reset_n),
      .req_i    (i_req),
      .update_i (arb_update_s),
      .grant_o  (arb_grant_s)
   );

   // Next-state and output decode; hdr_q marks that the byte in flight is the header.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      id_d      = id_q;
      cnt_d     = cnt_q;
      hdr_d     = hdr_q;
      grant_d   = 2'b00;
      busy_d    = busy_q;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      avail_d   = 1'b0;
      byte_d    = byte_q;

      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (arb_update_s) begin
               shift_d = arb_grant_s[1] ? i_word1 : i_word0;
               id_d    = arb_grant_s[1];
               cnt_d   = N_BYTES;
               grant_d = arb_grant_s;
               busy_d  = 1'b1;
               state_d = ST_GRANT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (HDR_EN) begin
               byte_d = header_byte(id_q);
               hdr_d  = 1'b1;
            end else begin
               byte_d = shift_q[7:0];
               hdr_d  = 1'b0;
            end
            state_d = ST_SEND;
         end
         ST_SEND: begin
            avail_d = 1'b1;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (i_tx_done) begin
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_d == {CW{1'b0}}) begin
                  done_d    = 1'b1;
                  done_id_d = id_q;
                  state_d   = ST_IDLE;
               end else begin
                  if (hdr_q) begin
                     hdr_d  = 1'b0;
                     byte_d = shift_q[7:0];
                  end else begin
                     shift_d = shift_q >> 8;
                     byte_d  = shift_d[7:0];
                  end
                  state_d = ST_SEND;
               end
            end else begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         shift_q   <= {W{1'b0}};
         id_q      <= 1'b0;
         cnt_q     <= {CW{1'b0}};
         hdr_q     <= 1'b0;
         grant_q   <= 2'b00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
         avail_q   <= 1'b0;
         byte_q    <= 8'h00;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         id_q      <= id_d;
         cnt_q     <= cnt_d;
         hdr_q     <= hdr_d;
         grant_q   <= grant_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         avail_q   <= avail_d;
         byte_q    <= byte_d;
      end
   end

   assign o_grant      = grant_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_done_id    = done_id_q;
   assign o_data_avail = avail_q;
   assign o_data_byte  = byte_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench: two scheduler instances, each driving a behavioural 8N1 byte transmitter.
module tb_uart_tx_scheduler;

   localparam int CPB    = 4;
   localparam int TXCLKS = 10 * CPB;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   logic [1:0]  req0 = 2'b00;
   logic [31:0] w00  = 32'h0000_0000;
   logic [31:0] w01  = 32'h0000_0000;
   logic [1:0]  grant0;
   logic        busy0, done0, done_id0, avail0;
   logic [7:0]  byte0;

   logic [1:0]  req1 = 2'b00;
   logic [7:0]  w10  = 8'h00;
   logic [7:0]  w11  = 8'h00;
   logic [1:0]  grant1;
   logic        busy1, done1, done_id1, avail1;
   logic [7:0]  byte1;

   logic [1:0] tx_active = 2'b00;
   logic [1:0] tx_done_m = 2'b00;
   logic [1:0] inj       = 2'b00;
   logic [1:0] tx_done_s;
   logic [1:0] avail_v;
   logic [7:0] byte_v [2];
   assign tx_done_s = tx_done_m | inj;
   assign avail_v   = {avail1, avail0};
   assign byte_v[0] = byte0;
   assign byte_v[1] = byte1;

   uart_tx_scheduler #(.WORD_BYTES(4), .SEND_HEADER(1)) dut (
      .clock(clock), .reset_n(reset_n), .i_req(req0), .i_word0(w00), .i_word1(w01),
      .o_grant(grant0), .o_busy(busy0), .o_done(done0), .o_done_id(done_id0),
      .o_data_avail(avail0), .o_data_byte(byte0),
      .i_tx_active(tx_active[0]), .i_tx_done(tx_done_s[0])
   );

   uart_tx_scheduler #(.WORD_BYTES(1), .SEND_HEADER(0)) dut1 (
      .clock(clock), .reset_n(reset_n), .i_req(req1), .i_word0(w10), .i_word1(w11),
      .o_grant(grant1), .o_busy(busy1), .o_done(done1), .o_done_id(done_id1),
      .o_data_avail(avail1), .o_data_byte(byte1),
      .i_tx_active(tx_active[1]), .i_tx_done(tx_done_s[1])
   );

   // Byte transmitters: accept a pulse only when idle, never reset, busy for one 10-bit frame.
   logic [7:0] tx_byte [2];
   int         tx_cnt  [2];
   int         lost_cnt = 0;
   logic [7:0] rx_q0[$];
   logic [7:0] rx_q1[$];

   always @(posedge clock) begin
      for (int k = 0; k < 2; k++) begin
         tx_done_m[k] <= 1'b0;
         if (!tx_active[k]) begin
            if (avail_v[k]) begin
               tx_active[k] <= 1'b1;
               tx_cnt[k]    <= TXCLKS - 1;
               tx_byte[k]   <= byte_v[k];
            end
         end else begin
            if (avail_v[k]) lost_cnt <= lost_cnt + 1;
            if (tx_cnt[k] == 0) begin
               tx_active[k] <= 1'b0;
               tx_done_m[k] <= 1'b1;
               if (k == 0) rx_q0.push_back(tx_byte[k]);
               else        rx_q1.push_back(tx_byte[k]);
            end else begin
               tx_cnt[k] <= tx_cnt[k] - 1;
            end
         end
      end
   end

   int          passed = 0;
   int          total  = 0;
   int          grant_log[$];
   int          done_log[$];
   int          exp_ids[$];
   logic [7:0]  exp_bytes[$];
   logic [31:0] pend_a[$];
   logic [31:0] pend_b[$];
   logic [31:0] mq_a[$];
   logic [31:0] mq_b[$];
   int          m_last      = 1;
   int          multi_grant = 0;
   int          grant_busy  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Reference: serve order by round-robin rule, byte stream = header then payload LSB-first.
   function automatic void model_order(input bit a_late);
      bit          first;
      bit          av;
      bit          bv;
      int          pick;
      logic [31:0] w;
      first = 1'b1;
      while (mq_a.size() > 0 || mq_b.size() > 0) begin
         av = (mq_a.size() > 0) && !(first && a_late);
         bv = (mq_b.size() > 0);
         if (!av && !bv) av = 1'b1;
         if (av && bv)   pick = (m_last == 1) ? 0 : 1;
         else if (av)    pick = 0;
         else            pick = 1;
         m_last = pick;
         first  = 1'b0;
         exp_ids.push_back(pick);
         if (pick == 0) w = mq_a.pop_front();
         else           w = mq_b.pop_front();
         exp_bytes.push_back(8'(160 + pick));
         for (int k = 0; k < 4; k++) exp_bytes.push_back(8'((w / (32'd1 << (8 * k))) % 32'd256));
      end
   endfunction

   // One cycle of the requester agents around dut: log events, drop on grant, raise queued words.
   task automatic step();
      @(negedge clock);
      if (grant0 != 2'b00) begin
         grant_log.push_back(grant0[1] ? 1 : 0);
         if (grant0 == 2'b11) multi_grant++;
         if (tx_active[0])    grant_busy++;
      end
      if (grant0[0]) req0[0] = 1'b0;
      if (grant0[1]) req0[1] = 1'b0;
      if (done0) done_log.push_back(int'(done_id0));
      if (!req0[0] && pend_a.size() > 0) begin w00 = pend_a.pop_front(); req0[0] = 1'b1; end
      if (!req0[1] && pend_b.size() > 0) begin w01 = pend_b.pop_front(); req0[1] = 1'b1; end
   endtask

   task automatic wait_words(input int n);
      int c;
      c = 0;
      while (done_log.size() < n && c < 400 * n + 100) begin step(); c++; end
      check("done_timeout", 64'(done_log.size() >= n), 64'd1);
      repeat (3) step();
   endtask

   task automatic clear_logs();
      grant_log.delete(); done_log.delete(); rx_q0.delete();
      exp_ids.delete(); exp_bytes.delete(); mq_a.delete(); mq_b.delete();
   endtask

   task automatic compare_logs(input string tag);
      check($sformatf("%s_ngrant", tag), 64'(grant_log.size()), 64'(exp_ids.size()));
      check($sformatf("%s_ndone", tag), 64'(done_log.size()), 64'(exp_ids.size()));
      check($sformatf("%s_nbytes", tag), 64'(rx_q0.size()), 64'(exp_bytes.size()));
      for (int i = 0; i < exp_ids.size(); i++) begin
         if (i < grant_log.size()) check($sformatf("%s_grant%0d", tag, i), 64'(grant_log[i]), 64'(exp_ids[i]));
         if (i < done_log.size())  check($sformatf("%s_doneid%0d", tag, i), 64'(done_log[i]), 64'(exp_ids[i]));
      end
      for (int i = 0; i < exp_bytes.size(); i++) begin
         if (i < rx_q0.size()) check($sformatf("%s_byte%0d", tag, i), 64'(rx_q0[i]), 64'(exp_bytes[i]));
      end
   endtask

   task automatic run_scenario(input string tag, input int na, input int nb, input bit a_late);
      int c;
      clear_logs();
      for (int i = 0; i < na; i++) mq_a.push_back($urandom);
      for (int i = 0; i < nb; i++) mq_b.push_back($urandom);
      if (a_late) begin
         foreach (mq_b[i]) pend_b.push_back(mq_b[i]);
         c = 0;
         while (grant_log.size() == 0 && c < 200) begin step(); c++; end
         check($sformatf("%s_first_grant", tag), 64'(grant_log.size() > 0), 64'd1);
         foreach (mq_a[i]) pend_a.push_back(mq_a[i]);
      end else begin
         foreach (mq_a[i]) pend_a.push_back(mq_a[i]);
         foreach (mq_b[i]) pend_b.push_back(mq_b[i]);
      end
      model_order(a_late);
      wait_words(na + nb);
      compare_logs(tag);
   endtask

   task automatic do_reset();
      reset_n = 1'b0; req0 = 2'b00; req1 = 2'b00;
      pend_a.delete(); pend_b.delete(); m_last = 1;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   // Single-byte word on the header-less instance: o_done the cycle after the transmitter's done.
   task automatic dut1_word(input bit id, input logic [7:0] b);
      int c;
      rx_q1.delete();
      if (id) begin w11 = b; req1 = 2'b10; end
      else    begin w10 = b; req1 = 2'b01; end
      @(negedge clock);
      check("w1_grant", 64'(grant1), id ? 64'd2 : 64'd1);
      req1 = 2'b00;
      c = 0;
      while (tx_done_m[1] == 1'b0 && c < 100) begin @(negedge clock); c++; end
      check("w1_txdone_seen", 64'(tx_done_m[1]), 64'd1);
      check("w1_done_early", 64'(done1), 64'd0);
      @(negedge clock);
      check("w1_done", 64'(done1), 64'd1);
      check("w1_done_id", 64'(done_id1), 64'(id));
      check("w1_busy_hold", 64'(busy1), 64'd1);
      @(negedge clock);
      check("w1_done_pulse", 64'(done1), 64'd0);
      check("w1_busy_fall", 64'(busy1), 64'd0);
      check("w1_nbytes", 64'(rx_q1.size()), 64'd1);
      if (rx_q1.size() > 0) check("w1_byte", 64'(rx_q1[0]), 64'(b));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int          c;
      int          viol;
      logic [7:0]  rb;
      logic [31:0] w;

      repeat (2) @(negedge clock);
      check("rst_grant0", 64'(grant0), 64'd0);
      check("rst_busy0", 64'(busy0), 64'd0);
      check("rst_done0", 64'(done0), 64'd0);
      check("rst_doneid0", 64'(done_id0), 64'd0);
      check("rst_avail0", 64'(avail0), 64'd0);
      check("rst_byte0", 64'(byte0), 64'd0);
      check("rst_grant1", 64'(grant1), 64'd0);
      check("rst_avail1", 64'(avail1), 64'd0);
      reset_n = 1'b1;
      @(negedge clock);

      run_scenario("tie1", 1, 1, 1'b0);
      run_scenario("tie2", 1, 1, 1'b0);
      run_scenario("alt", 2, 2, 1'b1);
      if (grant_log.size() == 4) begin
         check("alt_lit0", 64'(grant_log[0]), 64'd1);
         check("alt_lit1", 64'(grant_log[1]), 64'd0);
      end

      // Single request with fixed word: grant c+1, first byte pulse c+3.
      do_reset();
      clear_logs();
      mq_a.push_back(32'h1234_5678);
      pend_a.push_back(32'h1234_5678);
      model_order(1'b0);
      step();
      step();
      check("s1_grant", 64'(grant0), 64'd1);
      check("s1_busy", 64'(busy0), 64'd1);
      check("s1_avail_early", 64'(avail0), 64'd0);
      step();
      check("s1_grant_pulse", 64'(grant0), 64'd0);
      check("s1_avail_c2", 64'(avail0), 64'd0);
      step();
      check("s1_avail_c3", 64'(avail0), 64'd1);
      check("s1_hdr", 64'(byte0), 64'hA0);
      step();
      check("s1_avail_pulse", 64'(avail0), 64'd0);
      wait_words(1);
      compare_logs("single");

      dut1_word(1'b0, 8'hC3);
      rb = 8'($urandom);
      dut1_word(1'b1, rb);

      // Stray transmitter done while idle must be ignored.
      inj[1] = 1'b1;
      @(negedge clock);
      inj[1] = 1'b0;
      viol = 0;
      repeat (6) begin
         @(negedge clock);
         if (busy1 || avail1 || done1 || (grant1 != 2'b00)) viol++;
      end
      check("inj_quiet", 64'(viol), 64'd0);
      check("inj_byte_held", 64'(byte1), 64'(rb));
      check("inj_id_held", 64'(done_id1), 64'd1);
      dut1_word(1'b0, 8'($urandom));

      for (int r = 0; r < 3; r++) begin
         run_scenario($sformatf("rnd%0d", r), $urandom_range(0, 3), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
      end

      // Reset while the third byte of a word is on the wire.
      clear_logs();
      pend_a.push_back($urandom);
      c = 0;
      while (rx_q0.size() < 2 && c < 400) begin step(); c++; end
      check("mid_two_bytes", 64'(rx_q0.size() >= 2), 64'd1);
      c = 0;
      while (tx_active[0] == 1'b0 && c < 50) begin step(); c++; end
      check("mid_third_inflight", 64'(tx_active[0]), 64'd1);
      reset_n = 1'b0; req0 = 2'b00;
      pend_a.delete(); pend_b.delete(); m_last = 1;
      @(negedge clock);
      check("mid_rst_busy", 64'(busy0), 64'd0);
      check("mid_rst_byte", 64'(byte0), 64'd0);
      check("mid_rst_avail", 64'(avail0), 64'd0);
      reset_n = 1'b1;
      check("mid_tx_still_active", 64'(tx_active[0]), 64'd1);
      clear_logs();
      w = $urandom;
      mq_a.push_back(w);
      pend_a.push_back(w);
      model_order(1'b0);
      viol = 0;
      c = 0;
      while (tx_active[0] && c < 100) begin
         step();
         if (avail0 || (grant0 != 2'b00)) viol++;
         c++;
      end
      check("mid_gate", 64'(viol), 64'd0);
      check("mid_tx_idle", 64'(tx_active[0]), 64'd0);
      rx_q0.delete();
      wait_words(1);
      compare_logs("mid");

      check("lost_pulses", 64'(lost_cnt), 64'd0);
      check("multi_grant", 64'(multi_grant), 64'd0);
      check("grant_while_active", 64'(grant_busy), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin transmit scheduler that shares the single 8N1 UART byte transmitter between two result producers. Each producer presents a WORD_BYTES-byte word; the scheduler grants one producer, captures its word, optionally prefixes a header byte, and feeds the bytes LSB-first into the byte transmitter one at a time using its `i_data_avail`/`o_done` handshake. It sits between the modular-multiplier result paths and the UART byte transmitter.

## Interface
- WORD_BYTES, 4: payload bytes per word (1..16); word width W = 8*WORD_BYTES.
- SEND_HEADER, 1: when 1, a header byte `8'hA0 | id` precedes the payload.

- clock  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_req  in  2  per-requester level request; held until matching o_grant bit.
- i_word0  in  W  requester 0 word; stable while i_req[0]=1.
- i_word1  in  W  requester 1 word; stable while i_req[1]=1.
- o_grant  out  2  one-hot, one-cycle pulse: word captured, requester may drop i_req.
- o_busy  out  1  high from the grant cycle through the o_done cycle.
- o_done  out  1  one-cycle pulse after the last byte's transmitter done.
- o_done_id  out  1  requester id of the finished word; valid with o_done, held after.
- o_data_avail  out  1  to transmitter: one-cycle byte-valid pulse.
- o_data_byte  out  8  to transmitter: byte, held stable from pulse until next pulse.
- i_tx_active  in  1  from transmitter: byte in flight.
- i_tx_done  in  1  from transmitter: one-cycle end-of-byte pulse.

## Operation
- States: IDLE, GRANT, SEND, WAIT.
- IDLE: when i_req != 0 and i_tx_active == 0, arbiter picks a winner; capture word into shift register, set id, byte count N = WORD_BYTES + SEND_HEADER, pulse o_grant, go to GRANT. i_tx_done in IDLE is ignored.
- GRANT: load o_data_byte with header (`8'hA0 | id`) if SEND_HEADER else shift[7:0]; go to SEND.
- SEND: o_data_avail high this cycle only; go to WAIT.
- WAIT: on i_tx_done, decrement remaining count. If zero: pulse o_done, update o_done_id, go IDLE. Else: load next byte (shift register advances 8 bits after each payload byte; not after the header), go SEND.
- Arbitration: both requesting -> grant the one not served last; single request -> grant it. Pointer updates only on grant. After reset requester 0 wins a tie.
- Requests arriving while busy wait; no word is dropped or overwritten, since capture happens only at grant.
- i_req deasserted before grant: request withdrawn, no effect.

## Timing
- Reset (async assert): state IDLE, all outputs 0, o_data_byte 8'h00, RR pointer favours 0, shift register 0.
- Request seen in IDLE cycle c -> o_grant and o_busy high in cycle c+1 -> o_data_avail in cycle c+3.
- i_tx_done in cycle d -> next o_data_avail in cycle d+2, or o_done in cycle d+1 for the last byte. o_busy falls in cycle d+2.
- Next grant no earlier than the cycle after o_done.
- Reset mid-word: scheduler aborts immediately. The transmitter has no reset and finishes its byte. The IDLE gate on i_tx_active == 0 prevents an o_data_avail pulse from being lost while the transmitter is busy.
- The transmitter accepts o_data_avail only in its idle state. The scheduler never pulses o_data_avail except from SEND, which is entered only after grant or i_tx_done.

## Structure
- Package uart_sched_pkg: state encoding (2-bit), HEADER_BASE = 8'hA0, requester-id type.
- Sub-module rr_arbiter2: 2-input round-robin arbiter with a last-grant register. It has an update-enable input and a one-hot grant output.
- Byte count width: $clog2(WORD_BYTES+2).

## Test plan
Instantiate the real byte transmitter with CLKS_PER_BIT=4.
- Single request, i_word0=32'h1234_5678, SEND_HEADER=1 -> serial bytes A0,78,56,34,12; one o_done with o_done_id=0; o_grant[0] one cycle.
- Both requesters raise i_req in the same cycle right after reset -> requester 0 served first, then 1 (header A1). Repeat the tie -> requester 0 then 1 again, since the pointer alternates.
- Requester 1 holds i_req continuously while requester 0 re-requests after each done -> grants alternate 1,0,1,0 with no starvation.
- SEND_HEADER=0, WORD_BYTES=1, word 8'hC3 -> exactly one byte C3; o_done in the cycle after i_tx_done.
- Assert reset_n low mid-payload (after byte 2), release, raise a new request while the transmitter is still active -> no o_data_avail until i_tx_active falls; the new word is sent intact.
- i_tx_done pulse injected while in IDLE -> no state change and no output activity.
